mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LAT, 2, memory access latency in cycles from mem_en to valid mem_rdata (legal 1..15).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch read request, held until if_done.
REQ-005 if_addr  input  16  fetch address, stable while if_req.
REQ-006 if_rdata  output  16  fetch read data, valid with if_done.
REQ-007 if_done  output  1  one-cycle fetch completion pulse.
REQ-008 if_stall  output  1  fetch port must stall.
REQ-009 dm_rd  input  1  data read request, held until dm_done.
REQ-010 dm_wr  input  1  data write request, held until dm_done.
REQ-011 dm_addr  input  16  data address, stable while request.
REQ-012 dm_wdata  input  16  write data, stable while dm_wr.
REQ-013 dm_rdata  output  16  data read data, valid with dm_done.
REQ-014 dm_done  output  1  one-cycle data completion pulse.
REQ-015 dm_stall  output  1  data port must stall.
REQ-016 mem_en  output  1  one-cycle access strobe to single-ported memory.
REQ-017 mem_wr  output  1  write qualifier, valid only with mem_en.
REQ-018 mem_addr  output  16  latched access address.
REQ-019 mem_wdata  output  16  latched write data.
REQ-020 mem_rdata  input  16  memory read data, valid LAT cycles after mem_en.
REQ-021 err  output  1  sticky flag: dm_rd and dm_wr both seen high at a grant.

Function
REQ-022 FSM states IDLE, BUSY_IF, BUSY_DM; one access outstanding at a time.
REQ-023 IDLE: eligible requests = if_req (unless if_done high this cycle), dm_rd|dm_wr (unless dm_done high this cycle).
REQ-024 One eligible -> grant it; both eligible -> grant the port not granted last (last_grant register, round-robin).
REQ-025 On grant edge: state <- BUSY_x, cnt <- LAT-1, mem_addr/mem_wdata/mem_wr latched, mem_en <- 1 for exactly the first BUSY cycle.
REQ-026 mem_wr = dm_wr for data grants, 0 for fetch grants; dm_rd & dm_wr together -> write performed, err set.
REQ-027 BUSY_x: cnt decrements each cycle; at edge with cnt==0, state <- IDLE, x_rdata <- mem_rdata (writes: dm_rdata <- 0), x_done <- 1 for one cycle, last_grant <- x.
REQ-028 Latency: request first eligible in IDLE at cycle 0 -> x_done high in cycle LAT+1.
REQ-029 x_done cycle is IDLE; the other port may be granted in that same cycle (no bubble).
REQ-030 x_rdata holds last value until next completion on that port.
REQ-031 x_stall = request asserted & ~x_done (combinational); request deasserted -> stall 0.
REQ-032 Request dropped while BUSY for that port: access completes normally, done still pulses.
REQ-033 mem_en never asserted in two consecutive cycles unless LAT==1 with back-to-back grants; never while cnt!=LAT-1.

Reset
REQ-034 rst_n low (anytime, incl. mid-access): state IDLE, cnt 0, all outputs 0, mem_addr/mem_wdata/rdata regs 0, err 0, last_grant = IF (first conflict goes to DM).
REQ-035 Access in flight at reset abandoned; no done pulse after release.
REQ-036 First grant possible in first clock edge after rst_n rises.

Verification (LAT=2)
REQ-037 if_req, if_addr=0x0010, mem returns 0x1234 -> mem_en cycle 1 addr 0x0010 mem_wr 0, if_done & if_rdata=0x1234 cycle 3, if_stall high cycles 0-2.
REQ-038 if_req and dm_rd both at cycle 0 after reset -> DM granted first (dm_done cycle 3), IF granted cycle 3, if_done cycle 6.
REQ-039 Both held continuously, three accesses each -> strict alternation DM,IF,DM,IF,DM,IF; no port waits two grants.
REQ-040 dm_wr addr 0x00F0 wdata 0xBEEF -> mem_en & mem_wr cycle 1 with those values, dm_done cycle 3, dm_rdata 0.
REQ-041 rst_n low in cycle 2 of fetch -> all outputs 0 immediately, no if_done afterwards; new request after release completes in LAT+1.
REQ-042 dm_rd and dm_wr both high -> write performed, err set and held until reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter in front of a single-ported
// memory with a fixed access latency. One access is outstanding at a time.
// Simultaneous requests are served round-robin. All outputs are registered
// except the stall signals, which are combinational.
module mem_arbiter #(
  parameter int LAT = 2  // cycles from mem_en to valid mem_rdata, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_rdata_o,
  output logic        if_done_o,
  output logic        if_stall_o,
  // data port
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  input  logic [15:0] dm_addr_i,
  input  logic [15:0] dm_wdata_i,
  output logic [15:0] dm_rdata_o,
  output logic        dm_done_o,
  output logic        dm_stall_o,
  // memory side
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  // sticky protocol error
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        last_dm_q;   // 1 when the most recent completion was the data port
  logic [15:0] if_rdata_q;
  logic [15:0] dm_rdata_q;
  logic        if_done_q;
  logic        dm_done_q;
  logic        mem_en_q;
  logic        mem_wr_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        err_q;

  logic dm_req;
  logic if_elig;
  logic dm_elig;
  logic grant_if;
  logic grant_dm;

  // A port whose done pulse is high this cycle is still holding its old
  // request, so it is not eligible; this lets the other port go without a bubble.
  always_comb begin
    dm_req   = dm_rd_i | dm_wr_i;
    if_elig  = if_req_i & ~if_done_q;
    dm_elig  = dm_req & ~dm_done_q;
    grant_dm = dm_elig & (~if_elig | ~last_dm_q);
    grant_if = if_elig & ~grant_dm;
  end

  // Arbitration FSM with registered memory strobe, data and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_dm_q   <= 1'b0;
      if_rdata_q  <= 16'd0;
      dm_rdata_q  <= 16'd0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      // strobes are single-cycle by default
      mem_en_q  <= 1'b0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q     <= BUSY_DM;
            cnt_q       <= CNT_INIT;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= dm_wr_i;  // read+write together resolves to a write
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            if (dm_rd_i && dm_wr_i) begin
              err_q <= 1'b1;
            end
          end else if (grant_if) begin
            state_q    <= BUSY_IF;
            cnt_q      <= CNT_INIT;
            mem_en_q   <= 1'b1;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
          end
        end
        BUSY_IF: begin
          if (cnt_q == 4'd0) begin
            state_q    <= IDLE;
            if_rdata_q <= mem_rdata_i;
            if_done_q  <= 1'b1;
            last_dm_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        BUSY_DM: begin
          if (cnt_q == 4'd0) begin
            state_q    <= IDLE;
            dm_rdata_q <= mem_wr_q ? 16'd0 : mem_rdata_i;
            dm_done_q  <= 1'b1;
            last_dm_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Stall follows the live request; forced low while reset is held
  always_comb begin
    if_stall_o = rst_n & if_req_i & ~if_done_q;
    dm_stall_o = rst_n & dm_req & ~dm_done_q;
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with LAT=2.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic [15:0] if_rdata_o;
  logic        if_done_o;
  logic        if_stall_o;
  logic        dm_rd_i;
  logic        dm_wr_i;
  logic [15:0] dm_addr_i;
  logic [15:0] dm_wdata_i;
  logic [15:0] dm_rdata_o;
  logic        dm_done_o;
  logic        dm_stall_o;
  logic        mem_en_o;
  logic        mem_wr_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i;
  logic        err_o;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_arbiter #(.LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_rdata_o (if_rdata_o),
    .if_done_o  (if_done_o),
    .if_stall_o (if_stall_o),
    .dm_rd_i    (dm_rd_i),
    .dm_wr_i    (dm_wr_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_rdata_o (dm_rdata_o),
    .dm_done_o  (dm_done_o),
    .dm_stall_o (dm_stall_o),
    .mem_en_o   (mem_en_o),
    .mem_wr_o   (mem_wr_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory contents: 0x0010 holds 0x1234, everything else addr^0x5A5A
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // Memory model: read data captured at the edge that sees mem_en, held after
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_rdata_i <= 16'd0;
    else if (mem_en_o && !mem_wr_o) mem_rdata_i <= mem_val(mem_addr_o);
  end

  // One line per completed transaction
  always @(negedge clk) begin
    if (if_done_o) $display("[%0t] IF done  rdata=%h", $time, if_rdata_o);
    if (dm_done_o) $display("[%0t] DM done  rdata=%h err=%0b", $time, dm_rdata_o, err_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle's falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    int ifd;
    int dmd;
    int consec;
    int dn;
    int en;
    logic prev_en;
    logic [15:0] gaddr [6];

    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = 16'd0;
    dm_rd_i = 1'b0; dm_wr_i = 1'b0; dm_addr_i = 16'd0; dm_wdata_i = 16'd0;
    cyc(); cyc();
    settle();
    // reset state
    chk("rst_mem_en",   32'(mem_en_o),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_if_done",  32'(if_done_o),  32'd0);
    chk("rst_dm_done",  32'(dm_done_o),  32'd0);
    chk("rst_err",      32'(err_o),      32'd0);
    chk("rst_if_rdata", 32'(if_rdata_o), 32'd0);
    cyc();
    rst_n = 1'b1;

    // ---- single fetch ----
    cyc(); if_req_i = 1'b1; if_addr_i = 16'h0010; settle();           // cycle 0
    chk("f_stall_c0", 32'(if_stall_o), 32'd1);
    chk("f_en_c0",    32'(mem_en_o),   32'd0);
    cyc(); settle();                                                    // cycle 1
    chk("f_en_c1",    32'(mem_en_o),   32'd1);
    chk("f_addr_c1",  32'(mem_addr_o), 32'h0010);
    chk("f_wr_c1",    32'(mem_wr_o),   32'd0);
    chk("f_stall_c1", 32'(if_stall_o), 32'd1);
    cyc(); settle();                                                    // cycle 2
    chk("f_en_c2",    32'(mem_en_o),   32'd0);
    chk("f_done_c2",  32'(if_done_o),  32'd0);
    chk("f_stall_c2", 32'(if_stall_o), 32'd1);
    cyc(); settle();                                                    // cycle 3
    chk("f_done_c3",  32'(if_done_o),  32'd1);
    chk("f_rdata_c3", 32'(if_rdata_o), 32'h1234);
    chk("f_stall_c3", 32'(if_stall_o), 32'd0);
    if_req_i = 1'b0;
    cyc(); settle();                                                    // cycle 4
    chk("f_done_c4",  32'(if_done_o),  32'd0);
    chk("f_hold_c4",  32'(if_rdata_o), 32'h1234);

    // ---- single data write ----
    cyc(); dm_wr_i = 1'b1; dm_addr_i = 16'h00F0; dm_wdata_i = 16'hBEEF; settle();
    chk("w_stall_c0", 32'(dm_stall_o), 32'd1);
    cyc(); settle();
    chk("w_en_c1",    32'(mem_en_o),    32'd1);
    chk("w_wr_c1",    32'(mem_wr_o),    32'd1);
    chk("w_addr_c1",  32'(mem_addr_o),  32'h00F0);
    chk("w_wdata_c1", 32'(mem_wdata_o), 32'hBEEF);
    cyc(); settle();
    chk("w_done_c2",  32'(dm_done_o),   32'd0);
    cyc(); settle();
    chk("w_done_c3",  32'(dm_done_o),   32'd1);
    chk("w_rdata_c3", 32'(dm_rdata_o),  32'h0000);
    chk("w_err_c3",   32'(err_o),       32'd0);
    dm_wr_i = 1'b0;

    // ---- simultaneous requests right after reset: DM first ----
    do_reset();
    cyc(); if_req_i = 1'b1; if_addr_i = 16'h0020; dm_rd_i = 1'b1; dm_addr_i = 16'h0030; settle();
    cyc(); settle();                                                    // cycle 1
    chk("c_en_c1",    32'(mem_en_o),   32'd1);
    chk("c_addr_c1",  32'(mem_addr_o), 32'h0030);
    cyc(); cyc(); settle();                                             // cycle 3
    chk("c_dmdone_c3", 32'(dm_done_o),  32'd1);
    chk("c_dmrd_c3",   32'(dm_rdata_o), 32'h5A6A);
    chk("c_ifdone_c3", 32'(if_done_o),  32'd0);
    chk("c_ifstl_c3",  32'(if_stall_o), 32'd1);
    dm_rd_i = 1'b0;
    cyc(); settle();                                                    // cycle 4
    chk("c_en_c4",    32'(mem_en_o),   32'd1);
    chk("c_addr_c4",  32'(mem_addr_o), 32'h0020);
    cyc(); settle();                                                    // cycle 5
    chk("c_ifdone_c5", 32'(if_done_o), 32'd0);
    cyc(); settle();                                                    // cycle 6
    chk("c_ifdone_c6", 32'(if_done_o),  32'd1);
    chk("c_ifrd_c6",   32'(if_rdata_o), 32'h5A7A);
    if_req_i = 1'b0;

    // ---- both held: strict alternation, last grant was IF so DM leads ----
    cyc(); cyc();
    grants = 0; ifd = 0; dmd = 0; consec = 0; prev_en = 1'b0;
    for (int k = 0; k < 6; k++) gaddr[k] = 16'hFFFF;
    if_req_i = 1'b1; if_addr_i = 16'h0020; dm_rd_i = 1'b1; dm_addr_i = 16'h0030;
    for (int c = 0; c < 60 && (ifd < 3 || dmd < 3); c++) begin
      settle();
      if (mem_en_o) begin
        if (prev_en) consec++;
        if (grants < 6) gaddr[grants] = mem_addr_o;
        grants++;
      end
      prev_en = mem_en_o;
      if (if_done_o) begin ifd++; if (ifd == 3) if_req_i = 1'b0; end
      if (dm_done_o) begin dmd++; if (dmd == 3) dm_rd_i = 1'b0; end
      cyc();
    end
    if_req_i = 1'b0; dm_rd_i = 1'b0;
    chk("alt_grants", 32'(grants), 32'd6);
    chk("alt_ifdone", 32'(ifd),    32'd3);
    chk("alt_dmdone", 32'(dmd),    32'd3);
    chk("alt_consec", 32'(consec), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("alt_order%0d", k), 32'(gaddr[k]), (k % 2 == 0) ? 32'h0030 : 32'h0020);
    end

    // ---- reset in the middle of a fetch ----
    cyc(); cyc();
    cyc(); if_req_i = 1'b1; if_addr_i = 16'h0010; settle();           // cycle 0
    cyc(); settle();                                                    // cycle 1
    chk("r_en_c1", 32'(mem_en_o), 32'd1);
    cyc(); rst_n = 1'b0; settle();                                      // cycle 2
    chk("r_stall",  32'(if_stall_o), 32'd0);
    chk("r_addr",   32'(mem_addr_o), 32'd0);
    chk("r_rdata",  32'(if_rdata_o), 32'd0);
    chk("r_dmrd",   32'(dm_rdata_o), 32'd0);
    if_req_i = 1'b0;
    cyc(); cyc(); rst_n = 1'b1;
    dn = 0; en = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(); settle();
      if (if_done_o) dn++;
      if (mem_en_o) en++;
    end
    chk("r_no_done", 32'(dn), 32'd0);
    chk("r_no_en",   32'(en), 32'd0);
    cyc(); if_req_i = 1'b1; if_addr_i = 16'h0050; settle();           // cycle 0
    cyc(); cyc(); settle();                                             // cycle 2
    chk("r2_done_c2", 32'(if_done_o), 32'd0);
    cyc(); settle();                                                    // cycle 3
    chk("r2_done_c3", 32'(if_done_o),  32'd1);
    chk("r2_rd_c3",   32'(if_rdata_o), 32'h5A0A);
    if_req_i = 1'b0;

    // ---- read and write together: write wins, sticky err ----
    cyc(); dm_rd_i = 1'b1; dm_wr_i = 1'b1; dm_addr_i = 16'h0040; dm_wdata_i = 16'h5555; settle();
    chk("e_err_c0", 32'(err_o), 32'd0);
    cyc(); settle();
    chk("e_wr_c1",  32'(mem_wr_o),    32'd1);
    chk("e_wd_c1",  32'(mem_wdata_o), 32'h5555);
    chk("e_err_c1", 32'(err_o),       32'd1);
    cyc(); cyc(); settle();
    chk("e_done_c3", 32'(dm_done_o),  32'd1);
    chk("e_rd_c3",   32'(dm_rdata_o), 32'h0000);
    dm_rd_i = 1'b0; dm_wr_i = 1'b0;
    cyc(); cyc(); cyc(); settle();
    chk("e_err_held", 32'(err_o), 32'd1);
    do_reset();
    settle();
    chk("e_err_clr", 32'(err_o), 32'd0);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
